// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin owner of the register array write port with zero-fill sequencing
module regfile_write_arbiter #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    input  logic [BITS_ADDR-1:0] req0_addr,
    input  logic [BITS_DATA-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [BITS_ADDR-1:0] req1_addr,
    input  logic [BITS_DATA-1:0] req1_data,
    output logic                 req1_ready,
    input  logic                 clear_req,
    output logic                 wr_en,
    output logic [BITS_ADDR-1:0] wr_addr,
    output logic [BITS_DATA-1:0] wr_data,
    output logic                 init_done
);

    localparam int NUM_REGS = 2 ** BITS_ADDR;
    localparam logic [BITS_ADDR-1:0] LAST_ADDR = BITS_ADDR'(NUM_REGS - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t               state;
    state_t               stateNext;
    logic [BITS_ADDR-1:0] clrCnt;
    logic                 rrPtr;
    logic                 grant0;
    logic                 grant1;

    // State register; reset always restarts the zero-fill from address 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and grants; a clear request blocks both grants in the cycle it is seen.
    always_comb begin
        stateNext = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        case (state)
            CLEAR: begin
                if (clrCnt == LAST_ADDR) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (clear_req) begin
                    stateNext = CLEAR;
                end else begin
                    grant0 = req0_valid & (!req1_valid | (rrPtr == 1'b0));
                    grant1 = req1_valid & (!req0_valid | (rrPtr == 1'b1));
                end
            end
            default: stateNext = CLEAR;
        endcase
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Registered write port, clear counter, round-robin pointer and init flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clrCnt    <= '0;
            rrPtr     <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clrCnt;
                    wr_data <= '0;
                    if (clrCnt == LAST_ADDR) begin
                        clrCnt    <= '0;
                        init_done <= 1'b1;
                    end else begin
                        clrCnt <= clrCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (clear_req) begin
                        // rrPtr is deliberately left alone so fairness survives the clear.
                        wr_en     <= 1'b0;
                        init_done <= 1'b0;
                    end else if (grant0) begin
                        wr_en   <= 1'b1;
                        wr_addr <= req0_addr;
                        wr_data <= req0_data;
                        rrPtr   <= 1'b1;
                    end else if (grant1) begin
                        wr_en   <= 1'b1;
                        wr_addr <= req1_addr;
                        wr_data <= req1_data;
                        rrPtr   <= 1'b0;
                    end else begin
                        wr_en <= 1'b0;
                    end
                end
                default: begin
                    wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid;
    logic [2:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [2:0]  req1_addr;
    logic [31:0] req1_data;
    logic        req1_ready;
    logic        clear_req;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic        init_done;

    int passCnt;
    int totalCnt;

    regfile_write_arbiter #(.BITS_DATA(32), .BITS_ADDR(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; clear_req = 1'b0;
        req0_addr = 3'd1; req0_data = 32'h1111_1111; req1_addr = 3'd2; req1_data = 32'h2222_2222;
        step(); step();
        totalCnt++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got=%b exp=0", wr_en); else passCnt++;
        totalCnt++; if (wr_addr !== 3'd0) $display("FAIL rst_wr_addr got=%0d exp=0", wr_addr); else passCnt++;
        totalCnt++; if (wr_data !== 32'd0) $display("FAIL rst_wr_data got=%h exp=0", wr_data); else passCnt++;
        totalCnt++; if (init_done !== 1'b0) $display("FAIL rst_init_done got=%b exp=0", init_done); else passCnt++;
        totalCnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rst_readys got=%b exp=00", {req0_ready, req1_ready}); else passCnt++;
        rst_n = 1'b1;
        clear_req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 7) begin
                req0_valid = 1'b0; req1_valid = 1'b0; clear_req = 1'b0;
                #1;
            end
            totalCnt++; if (wr_en !== 1'b1) $display("FAIL init_wr_en[%0d] got=%b exp=1", k, wr_en); else passCnt++;
            totalCnt++; if (wr_addr !== 3'(k)) $display("FAIL init_wr_addr[%0d] got=%0d exp=%0d", k, wr_addr, k); else passCnt++;
            totalCnt++; if (wr_data !== 32'd0) $display("FAIL init_wr_data[%0d] got=%h exp=0", k, wr_data); else passCnt++;
            totalCnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL init_readys[%0d] got=%b exp=00", k, {req0_ready, req1_ready}); else passCnt++;
            if (k < 7) begin
                totalCnt++; if (init_done !== 1'b0) $display("FAIL init_done_early[%0d] got=%b exp=0", k, init_done); else passCnt++;
            end
        end
        step();
        totalCnt++; if (init_done !== 1'b1) $display("FAIL init_done_set got=%b exp=1", init_done); else passCnt++;
        totalCnt++; if (wr_en !== 1'b0) $display("FAIL init_idle_wr_en got=%b exp=0", wr_en); else passCnt++;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 32'hDEAD_BEEF;
        #1;
        totalCnt++; if (req0_ready !== 1'b1) $display("FAIL single_ready0 got=%b exp=1", req0_ready); else passCnt++;
        totalCnt++; if (req1_ready !== 1'b0) $display("FAIL single_ready1 got=%b exp=0", req1_ready); else passCnt++;
        step();
        req0_valid = 1'b0;
        totalCnt++; if (wr_en !== 1'b1) $display("FAIL single_wr_en got=%b exp=1", wr_en); else passCnt++;
        totalCnt++; if (wr_addr !== 3'd3) $display("FAIL single_wr_addr got=%0d exp=3", wr_addr); else passCnt++;
        totalCnt++; if (wr_data !== 32'hDEAD_BEEF) $display("FAIL single_wr_data got=%h exp=deadbeef", wr_data); else passCnt++;
        step();
        totalCnt++; if (wr_en !== 1'b0) $display("FAIL single_idle_wr_en got=%b exp=0", wr_en); else passCnt++;
        totalCnt++; if ({wr_addr, wr_data} !== {3'd3, 32'hDEAD_BEEF}) $display("FAIL single_hold got=%0d/%h exp=3/deadbeef", wr_addr, wr_data); else passCnt++;
    endtask

    task automatic test_req1_burst();
        for (int k = 0; k < 3; k++) begin
            req1_valid = 1'b1; req1_addr = 3'(5 + k); req1_data = 32'h100 + 32'(k);
            #1;
            totalCnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL burst_readys[%0d] got=%b exp=01", k, {req0_ready, req1_ready}); else passCnt++;
            step();
            totalCnt++; if (wr_en !== 1'b1) $display("FAIL burst_wr_en[%0d] got=%b exp=1", k, wr_en); else passCnt++;
            totalCnt++; if (wr_addr !== 3'(5 + k)) $display("FAIL burst_wr_addr[%0d] got=%0d exp=%0d", k, wr_addr, 5 + k); else passCnt++;
            totalCnt++; if (wr_data !== 32'h100 + 32'(k)) $display("FAIL burst_wr_data[%0d] got=%h exp=%h", k, wr_data, 32'h100 + 32'(k)); else passCnt++;
        end
        req1_valid = 1'b0;
        step();
    endtask

    task automatic test_fairness();
        logic [31:0] dataA [4];
        logic [31:0] dataB [4];
        int ia;
        int ib;
        dataA = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        dataB = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        ia = 0; ib = 0;
        for (int c = 0; c < 8; c++) begin
            req0_valid = (ia < 4); req0_addr = 3'(ia % 4); req0_data = dataA[ia % 4];
            req1_valid = (ib < 4); req1_addr = 3'(4 + (ib % 4)); req1_data = dataB[ib % 4];
            #1;
            if (c % 2 == 0) begin
                totalCnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rr_readys[%0d] got=%b exp=10", c, {req0_ready, req1_ready}); else passCnt++;
            end else begin
                totalCnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL rr_readys[%0d] got=%b exp=01", c, {req0_ready, req1_ready}); else passCnt++;
            end
            step();
            totalCnt++; if (wr_en !== 1'b1) $display("FAIL rr_wr_en[%0d] got=%b exp=1", c, wr_en); else passCnt++;
            if (c % 2 == 0) begin
                totalCnt++; if ({wr_addr, wr_data} !== {3'(ia), dataA[ia]}) $display("FAIL rr_write[%0d] got=%0d/%h exp=%0d/%h", c, wr_addr, wr_data, ia, dataA[ia]); else passCnt++;
                ia++;
            end else begin
                totalCnt++; if ({wr_addr, wr_data} !== {3'(4 + ib), dataB[ib]}) $display("FAIL rr_write[%0d] got=%0d/%h exp=%0d/%h", c, wr_addr, wr_data, 4 + ib, dataB[ib]); else passCnt++;
                ib++;
            end
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    task automatic test_clear();
        req0_valid = 1'b1; req0_addr = 3'd6; req0_data = 32'hC0C0_0000;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 32'hC1C1_1111;
        clear_req = 1'b1;
        #1;
        totalCnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL clr_req_readys got=%b exp=00", {req0_ready, req1_ready}); else passCnt++;
        step();
        clear_req = 1'b0;
        totalCnt++; if (wr_en !== 1'b0) $display("FAIL clr_gap_wr_en got=%b exp=0", wr_en); else passCnt++;
        totalCnt++; if (init_done !== 1'b0) $display("FAIL clr_init_drop got=%b exp=0", init_done); else passCnt++;
        for (int k = 0; k < 8; k++) begin
            if (k < 7) begin
                totalCnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL clr_readys[%0d] got=%b exp=00", k, {req0_ready, req1_ready}); else passCnt++;
            end
            step();
            totalCnt++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'(k), 32'd0}) $display("FAIL clr_write[%0d] got=%b/%0d/%h exp=1/%0d/0", k, wr_en, wr_addr, wr_data, k); else passCnt++;
        end
        totalCnt++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL clr_rr_kept got=%b exp=10", {req0_ready, req1_ready}); else passCnt++;
        step();
        totalCnt++; if (init_done !== 1'b1) $display("FAIL clr_init_back got=%b exp=1", init_done); else passCnt++;
        totalCnt++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd6, 32'hC0C0_0000}) $display("FAIL clr_resume0 got=%b/%0d/%h exp=1/6/c0c00000", wr_en, wr_addr, wr_data); else passCnt++;
        req0_valid = 1'b0;
        #1;
        totalCnt++; if ({req0_ready, req1_ready} !== 2'b01) $display("FAIL clr_resume_readys got=%b exp=01", {req0_ready, req1_ready}); else passCnt++;
        step();
        req1_valid = 1'b0;
        totalCnt++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'd2, 32'hC1C1_1111}) $display("FAIL clr_resume1 got=%b/%0d/%h exp=1/2/c1c11111", wr_en, wr_addr, wr_data); else passCnt++;
        step();
    endtask

    task automatic test_reset_midclear();
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
        end
        totalCnt++; if ({wr_en, wr_addr} !== {1'b1, 3'd3}) $display("FAIL mid_fourth_write got=%b/%0d exp=1/3", wr_en, wr_addr); else passCnt++;
        #1 rst_n = 1'b0;
        #1;
        totalCnt++; if (wr_en !== 1'b0) $display("FAIL mid_async_wr_en got=%b exp=0", wr_en); else passCnt++;
        totalCnt++; if ({wr_addr, init_done} !== {3'd0, 1'b0}) $display("FAIL mid_async_state got=%0d/%b exp=0/0", wr_addr, init_done); else passCnt++;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            totalCnt++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 3'(k), 32'd0}) $display("FAIL mid_restart[%0d] got=%b/%0d/%h exp=1/%0d/0", k, wr_en, wr_addr, wr_data, k); else passCnt++;
        end
        step();
        totalCnt++; if ({wr_en, init_done} !== 2'b01) $display("FAIL mid_done got=%b/%b exp=0/1", wr_en, init_done); else passCnt++;
    endtask

    initial begin
        passCnt = 0;
        totalCnt = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_req1_burst();
        test_fairness();
        test_clear();
        test_reset_midclear();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
